seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU. Supports the same 4-bit aluc operation set at configurable WIDTH.
- Adds iterative multiply and divide units, selected by a fifth opcode bit.
- Valid/ready handshake on both sides, so the pipeline stalls its EX stage while a multi-cycle operation is in flight.
- Results are registered and delivered as lo/hi words: hi holds the upper product or the remainder.

Parameters:
- WIDTH, 32, operand/result width; even, ≥8.
- SHW, $clog2(WIDTH), shift-amount bits taken from a[SHW-1:0].

Ports:
- clock  in  1  single system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op present.
- in_ready  out  1  block accepts op this cycle.
- op  in  5  op[4]=0: legacy aluc in op[3:0]; op[4]=1: mul/div group.
- a  in  WIDTH  operand A (shift amount for shifts).
- b  in  WIDTH  operand B.
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  consumer takes result.
- r_lo  out  WIDTH  primary result / low product / quotient.
- r_hi  out  WIDTH  high product / remainder; 0 for single-cycle ops.
- busy  out  1  multi-cycle op in progress.

Behaviour:
- Accept: in_valid & in_ready at a rising edge.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- States: IDLE, MUL, DIV, DONE.
- Single-cycle ops (op[4]=0), result registered, IDLE→DONE:
  - x000 add.
  - x100 sub.
  - x001 and.
  - x101 or.
  - x010 xor.
  - x110 b<<(WIDTH/2).
  - 0011 b<<a[SHW-1:0].
  - 0111 logical b>>a[SHW-1:0].
  - 1111 arithmetic b>>>a[SHW-1:0].
  - 1011 → 0.
  - Add/sub wrap modulo 2^WIDTH.
  - out_valid rises on the edge after accept (latency 1).
- Mul/div ops:
  - 10000 MULU.
  - 10001 MUL signed.
  - 10010 DIVU.
  - 10011 DIV signed.
  - 101xx/11xxx → single-cycle, r_lo=r_hi=0.
- MUL:
  - Radix-2 shift-add on operand magnitudes.
  - Exactly WIDTH iterations; final sign fix in the last iteration.
  - Full 2*WIDTH product: {r_hi,r_lo}.
  - out_valid asserts WIDTH+1 edges after accept.
- DIV:
  - Restoring, WIDTH iterations on magnitudes; out_valid at WIDTH+1 edges.
  - Quotient sign = sign(a)^sign(b); remainder takes the sign of a.
  - b==0: r_lo=all ones, r_hi=a, same latency.
  - Signed MIN/−1: r_lo=MIN, r_hi=0.
- busy = state∈{MUL,DIV}. Operands are latched at accept; input changes during busy are ignored.
- DONE: r_lo/r_hi/out_valid held stable until out_ready.
  - out_ready with in_valid: new op accepted in the same edge (back-to-back, 1 op/cycle for single-cycle ops).
  - out_ready without in_valid: DONE→IDLE.
- Reset (any time, including mid-iteration):
  - State→IDLE, out_valid=0, busy=0, r_lo=r_hi=0, iteration counter=0.
  - The aborted op produces no output.
- out_valid and in_ready are never both driven from combinational in_valid (no in→out comb path except in_ready←out_ready).

Optional Feature:
- SEQ_ALU_DIV_EN defined: divider present as above.
- Undefined:
  - No divider logic.
  - 10010/10011 complete as single-cycle ops with r_lo=r_hi=0; DIV state unreachable.
  - MUL unaffected.

Test Plan:
- Reset mid-MULU (resetn low at iteration 5) → out_valid=0, busy=0, r_lo=r_hi=0; next ADD 3+4 → r_lo=7 one edge after accept.
- Legacy ops, WIDTH=32:
  - SUB 5−7 → 0xFFFFFFFE.
  - LUI b=0x1234 → 0x12340000.
  - SRA a=4, b=0x80000000 → 0xF8000000.
  - op 01011 → 0.
- MUL a=−3, b=7 → {r_hi,r_lo}=0xFFFFFFFF_FFFFFFEB after 33 edges.
- MULU 0xFFFFFFFF², out_ready held low 3 cycles → r_hi=0xFFFFFFFE, r_lo=1, stable until out_ready.
- DIV:
  - −7/2 → q=−3, r=−1.
  - DIVU 9/0 → q=0xFFFFFFFF, r=9.
  - DIV 0x80000000/−1 → q=0x80000000, r=0.
  - Without SEQ_ALU_DIV_EN → all zero, latency 1.
- Back-to-back ADD, XOR, OR with out_ready=1 → three results on three consecutive edges, in_ready constantly 1.

Source files
------------

// File: rtl/seq_alu.sv
// Registered multi-cycle ALU: the legacy single-cycle op set plus iterative MUL/DIV, with valid/ready on both sides.
// Define SEQ_ALU_DIV_EN to build the restoring divider; without it DIVU/DIV complete in one cycle with zero results.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r_lo,
    output logic [WIDTH-1:0] r_hi,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             is_mul;
    logic             is_div;
    logic             last;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] single_res;

    // Operand magnitudes and sign bookkeeping for the iterative units
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] opb;
    logic             neg_lo;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nx;

`ifdef SEQ_ALU_DIV_EN
    logic             neg_hi;
    logic             dzero;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_lo;
    logic [WIDTH-1:0] div_hi;
`endif

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign out_valid = (state == DONE);
    assign busy      = (state == MUL) | (state == DIV);
    assign accept    = in_valid & in_ready;
    assign last      = (cnt == LAST);
    assign sh        = a[SHW-1:0];

    assign is_mul = op[4] & (op[3:1] == 3'b000);
`ifdef SEQ_ALU_DIV_EN
    assign is_div = op[4] & (op[3:1] == 3'b001);
`else
    assign is_div = 1'b0;
`endif

    assign a_neg = op[0] & a[WIDTH-1];
    assign b_neg = op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        single_res = '0;
        if (!op[4]) begin
            casez (op[3:0])
                4'b?000: single_res = a + b;
                4'b?100: single_res = a - b;
                4'b?001: single_res = a & b;
                4'b?101: single_res = a | b;
                4'b?010: single_res = a ^ b;
                4'b?110: single_res = b << (WIDTH / 2);
                4'b0011: single_res = b << sh;
                4'b0111: single_res = b >> sh;
                4'b1111: single_res = $signed(b) >>> sh;
                default: single_res = '0;
            endcase
        end
    end

    // Shift-add step: r_lo holds the remaining multiplier bits, r_hi the partial product.
    always_comb begin
        mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, opb} : '0);
        mul_nx  = {mul_sum, r_lo[WIDTH-1:1]};
        if (last && neg_lo) begin
            mul_nx = -mul_nx;
        end
    end

`ifdef SEQ_ALU_DIV_EN
    // Restoring step: r_hi is the partial remainder, r_lo shifts dividend bits out and quotient bits in.
    always_comb begin
        div_sh   = {r_hi, r_lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb};
        div_ge   = ~div_diff[WIDTH];
        div_hi   = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
        div_lo   = {r_lo[WIDTH-2:0], div_ge};
        if (last) begin
            if (dzero) begin
                div_lo = '1;
            end else if (neg_lo) begin
                div_lo = -div_lo;
            end
            if (neg_hi) begin
                div_hi = -div_hi;
            end
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_nx = MUL;
                    end else if (is_div) begin
                        state_nx = DIV;
                    end else begin
                        state_nx = DONE;
                    end
                end else if (state == DONE && out_ready) begin
                    state_nx = IDLE;
                end
            end
            MUL, DIV: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The result registers double as the iteration working registers; nothing observes them until DONE.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_lo   <= '0;
            r_hi   <= '0;
            opb    <= '0;
            neg_lo <= 1'b0;
            cnt    <= '0;
`ifdef SEQ_ALU_DIV_EN
            neg_hi <= 1'b0;
            dzero  <= 1'b0;
`endif
        end else if (accept) begin
            cnt <= '0;
            if (is_mul || is_div) begin
                r_lo   <= a_mag;
                r_hi   <= '0;
                opb    <= b_mag;
                neg_lo <= a_neg ^ b_neg;
`ifdef SEQ_ALU_DIV_EN
                neg_hi <= a_neg;
                dzero  <= (b == '0);
`endif
            end else begin
                r_lo <= single_res;
                r_hi <= '0;
            end
        end else if (state == MUL) begin
            {r_hi, r_lo} <= mul_nx;
            cnt          <= cnt + 1'b1;
        end
`ifdef SEQ_ALU_DIV_EN
        else if (state == DIV) begin
            r_hi <= div_hi;
            r_lo <= div_lo;
            cnt  <= cnt + 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a driver pushes model results at accept, a monitor pops them as results appear.
module tb_seq_alu;

    localparam int W = 32;

    logic         clock;
    logic         resetn;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] r_lo;
    logic [W-1:0] r_hi;
    logic         busy;

    logic hold_low;
    logic rand_mode;
    logic rnd_bit;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic prev_valid = 1'b0;
    logic prev_taken = 1'b0;

    seq_alu #(.WIDTH(W)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_lo      (r_lo),
        .r_hi      (r_hi),
        .busy      (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) rnd_bit = ($urandom_range(0, 3) != 0);
    assign out_ready = hold_low ? 1'b0 : (rand_mode ? rnd_bit : 1'b1);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference model straight from the op table, using 64-bit host arithmetic.
    function automatic void model(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi, output int lat);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] p;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        lo  = '0;
        hi  = '0;
        lat = 1;
        if (!o[4]) begin
            case (o[2:0])
                3'b000: lo = x + y;
                3'b100: lo = x - y;
                3'b001: lo = x & y;
                3'b101: lo = x | y;
                3'b010: lo = x ^ y;
                3'b110: lo = {y[15:0], 16'h0000};
                default: begin
                    case (o[3:2])
                        2'b00:   lo = y << x[4:0];
                        2'b01:   lo = y >> x[4:0];
                        2'b11:   lo = 32'(sy >>> x[4:0]);
                        default: lo = '0;
                    endcase
                end
            endcase
        end else if (o[3:1] == 3'b000) begin
            lat = W + 1;
            if (o[0]) p = sx * sy;
            else      p = {32'h0, x} * {32'h0, y};
            hi = p[63:32];
            lo = p[31:0];
        end else if (o[3:1] == 3'b001) begin
`ifdef SEQ_ALU_DIV_EN
            lat = W + 1;
            if (y == 0) begin
                lo = '1;
                hi = x;
            end else if (o[0]) begin
                q  = sx / sy;
                r  = sx % sy;
                lo = 32'(q);
                hi = 32'(r);
            end else begin
                lo = x / y;
                hi = x % y;
            end
`endif
        end
    endfunction

    task automatic issue(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int waits);
        exp_t e;
        @(negedge clock);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        waits    = 0;
        #1;
        while (!in_ready && waits < 200) begin
            @(negedge clock);
            #1;
            waits++;
        end
        if (!in_ready) begin
            fail("in_ready_wait");
            in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        e.op = o;
        model(o, x, y, e.lo, e.hi, e.lat);
        e.acc = cyc;
        sb.push_back(e);
        // Scramble operands after accept: the DUT must have latched them.
        in_valid = 1'b0;
        op       = 5'($urandom);
        a        = $urandom;
        b        = $urandom;
    endtask

    task automatic drain();
        int n;
        rand_mode = 1'b0;
        hold_low  = 1'b0;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (sb.size() != 0 || out_valid) fail("drain");
    endtask

    always @(negedge clock) begin
        #2;
        if (!resetn) begin
            prev_valid = 1'b0;
            prev_taken = 1'b0;
        end else begin
            if (out_valid) begin
                if (!prev_valid || prev_taken) begin
                    if (sb.size() == 0) begin
                        fail("unexpected_result");
                    end else begin
                        cur = sb.pop_front();
                        check($sformatf("r_lo op=%05b", cur.op), r_lo, cur.lo);
                        check($sformatf("r_hi op=%05b", cur.op), r_hi, cur.hi);
                        check($sformatf("latency op=%05b", cur.op), cyc - cur.acc + 1, cur.lat);
                    end
                end else begin
                    check($sformatf("hold_lo op=%05b", cur.op), r_lo, cur.lo);
                    check($sformatf("hold_hi op=%05b", cur.op), r_hi, cur.hi);
                end
            end
            prev_valid = out_valid;
            prev_taken = out_ready;
        end
    end

    initial begin
        int w;
        int n;
        logic [4:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        resetn    = 1'b1;
        in_valid  = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        hold_low  = 1'b0;
        rand_mode = 1'b0;
        #1 resetn = 1'b0;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_r_lo", r_lo, 0);
        check("rst_r_hi", r_hi, 0);
        check("rst_in_ready", in_ready, 1);
        #8 resetn = 1'b1;

        // Legacy and mul/div directed cases
        issue(5'b00100, 32'd5, 32'd7, w);
        issue(5'b00110, 32'hDEAD_BEEF, 32'h0000_1234, w);
        issue(5'b01111, 32'd4, 32'h8000_0000, w);
        issue(5'b01011, 32'h1234_5678, 32'h9ABC_DEF0, w);
        issue(5'b10001, 32'hFFFF_FFFD, 32'd7, w);
        issue(5'b10011, 32'hFFFF_FFF9, 32'd2, w);
        issue(5'b10010, 32'd9, 32'd0, w);
        issue(5'b10011, 32'h8000_0000, 32'hFFFF_FFFF, w);
        drain();

        // MULU with backpressure: result must hold while out_ready stays low
        hold_low = 1'b1;
        issue(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (!out_valid) fail("mulu_out_valid");
        repeat (3) begin
            check("hold_in_ready", in_ready, 0);
            @(negedge clock);
            #1;
        end
        hold_low = 1'b0;
        drain();

        // Reset in the middle of a MULU: aborted op must leave no trace
        issue(5'b10000, 32'd1234, 32'd5678, w);
        repeat (5) @(posedge clock);
        @(negedge clock);
        #1;
        check("mid_busy", busy, 1);
        resetn = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_r_lo", r_lo, 0);
        check("abort_r_hi", r_hi, 0);
        sb.delete();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        issue(5'b00000, 32'd3, 32'd4, w);
        drain();

        // Back-to-back single-cycle ops with the consumer always ready
        issue(5'b00000, 32'h0000_00FF, 32'h0000_0001, w);
        check("b2b_wait_add", w, 0);
        issue(5'b00010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, w);
        check("b2b_wait_xor", w, 0);
        issue(5'b00101, 32'h1200_0034, 32'h0056_7800, w);
        check("b2b_wait_or", w, 0);
        drain();

        // Random ops with random backpressure
        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ro = 5'($urandom_range(0, 31));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 9));
                2: ra = 32'h8000_0000;
                3: rb = '1;
                default: ;
            endcase
            issue(ro, ra, rb, w);
            if ($urandom_range(0, 3) == 0) @(negedge clock);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
